vec_fp_mul_engine: RTL

Parametrised vector single-precision (IEEE-754 binary32) multiplier engine for the vector FP datapath. It holds two operand vector banks and one result bank, each VLEN deep. On start it streams element pairs A[i]*B[i] through a 3-stage pipeline and writes the products and per-element exception flags into the result bank. Next generation of the single-vector multiplier, adding configurable length, a load/readback interface, round-to-nearest-even and full special-value handling.

---
 rtl/vfpm_pkg.sv | 46 ++++
 rtl/fp32_mul_pipe.sv | 176 +++++++++++++++++
 rtl/vec_fp_mul_engine.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vfpm_pkg.sv
// -----------------------------------------------------------------------------
// vfpm_pkg
// Shared definitions for the vector FP32 multiplier engine:
//   - binary32 field widths and exponent bias
//   - canonical quiet NaN produced for invalid operations
//   - bit positions inside the 3-bit {inv, ovf, unf} flag vector
//   - engine FSM state encoding
//   - operand classification helper
// -----------------------------------------------------------------------------
package vfpm_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_ALL = 8'hFF;

  // Flag vector layout: {inv, ovf, unf}
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;  // exponent field 0: true zero or denormal (flushed)
    logic inf;
    logic nan;
  } fp_class_t;

  // Classify one binary32 operand; denormals are reported as zero.
  function automatic fp_class_t fp32_classify(input logic [FP_W-1:0] v);
    fp_class_t c;
    c.zero = (v[MAN_W +: EXP_W] == 8'h00);
    c.inf  = (v[MAN_W +: EXP_W] == EXP_ALL) && (v[MAN_W-1:0] == 23'h0);
    c.nan  = (v[MAN_W +: EXP_W] == EXP_ALL) && (v[MAN_W-1:0] != 23'h0);
    return c;
  endfunction

endpackage

// File: rtl/fp32_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp32_mul_pipe
// Three-stage binary32 multiplier with valid/index sideband.
//   S1: classify operands, sign XOR, 10-bit signed exponent ea+eb-127
//   S2: 24x24 mantissa product
//   S3: normalise, round-to-nearest-even, special-value selection, pack
// Ports:
//   Clk, reset              clock / async active-low reset
//   in_valid, in_idx        issue strobe and element index
//   in_a, in_b              operands
//   out_valid, out_idx      registered S3 strobe and element index
//   out_data, out_flags     registered product and {inv, ovf, unf}
// -----------------------------------------------------------------------------
module fp32_mul_pipe
  import vfpm_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_idx,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          out_valid,
  output logic [AW-1:0] out_idx,
  output logic [31:0]   out_data,
  output logic [2:0]    out_flags
);

  // ---------------- S1 ----------------
  fp_class_t  ca_s;
  fp_class_t  cb_s;
  logic       s1_inv_s;
  logic       s1_inf_s;
  logic       s1_zero_s;
  logic [9:0] s1_exp_s;

  logic          s1_valid_r;
  logic [AW-1:0] s1_idx_r;
  logic          s1_sign_r;
  logic [9:0]    s1_exp_r;
  logic          s1_inv_r;
  logic          s1_inf_r;
  logic          s1_zero_r;
  logic [23:0]   s1_ma_r;
  logic [23:0]   s1_mb_r;

  // Operand classification and exponent sum (10-bit two's complement)
  always_comb begin
    ca_s      = fp32_classify(in_a);
    cb_s      = fp32_classify(in_b);
    s1_inv_s  = ca_s.nan | cb_s.nan | (ca_s.inf & cb_s.zero) | (ca_s.zero & cb_s.inf);
    s1_inf_s  = ca_s.inf | cb_s.inf;
    s1_zero_s = ca_s.zero | cb_s.zero;
    s1_exp_s  = {2'b00, in_a[30:23]} + {2'b00, in_b[30:23]} - 10'(BIAS);
  end

  // S1 pipeline register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_idx_r   <= '0;
      s1_sign_r  <= 1'b0;
      s1_exp_r   <= 10'd0;
      s1_inv_r   <= 1'b0;
      s1_inf_r   <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_ma_r    <= 24'd0;
      s1_mb_r    <= 24'd0;
    end else begin
      s1_valid_r <= in_valid;
      s1_idx_r   <= in_idx;
      s1_sign_r  <= in_a[31] ^ in_b[31];
      s1_exp_r   <= s1_exp_s;
      s1_inv_r   <= s1_inv_s;
      s1_inf_r   <= s1_inf_s;
      s1_zero_r  <= s1_zero_s;
      s1_ma_r    <= {1'b1, in_a[22:0]};
      s1_mb_r    <= {1'b1, in_b[22:0]};
    end
  end

  // ---------------- S2 ----------------
  logic          s2_valid_r;
  logic [AW-1:0] s2_idx_r;
  logic          s2_sign_r;
  logic [9:0]    s2_exp_r;
  logic          s2_inv_r;
  logic          s2_inf_r;
  logic          s2_zero_r;
  logic [47:0]   s2_prod_r;

  // S2 pipeline register holding the full 48-bit mantissa product
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      s2_idx_r   <= '0;
      s2_sign_r  <= 1'b0;
      s2_exp_r   <= 10'd0;
      s2_inv_r   <= 1'b0;
      s2_inf_r   <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_prod_r  <= 48'd0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_idx_r   <= s1_idx_r;
      s2_sign_r  <= s1_sign_r;
      s2_exp_r   <= s1_exp_r;
      s2_inv_r   <= s1_inv_r;
      s2_inf_r   <= s1_inf_r;
      s2_zero_r  <= s1_zero_r;
      s2_prod_r  <= {24'd0, s1_ma_r} * {24'd0, s1_mb_r};
    end
  end

  // ---------------- S3 ----------------
  logic        norm_s;
  logic [23:0] mant_s;
  logic        guard_s;
  logic        sticky_s;
  logic        round_up_s;
  logic [24:0] mant_rnd_s;
  logic [22:0] frac_s;
  logic [9:0]  exp_fin_s;
  logic [31:0] res_data_s;
  logic [2:0]  res_flags_s;

  // Normalise, round to nearest-even, then apply special-value priority
  always_comb begin
    norm_s     = s2_prod_r[47];
    mant_s     = norm_s ? s2_prod_r[47:24] : s2_prod_r[46:23];
    guard_s    = norm_s ? s2_prod_r[23]    : s2_prod_r[22];
    sticky_s   = norm_s ? (|s2_prod_r[22:0]) : (|s2_prod_r[21:0]);
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {24'd0, round_up_s};
    // A carry out of rounding leaves 1.000..0, so the shifted fraction is zero.
    frac_s     = mant_rnd_s[24] ? mant_rnd_s[23:1] : mant_rnd_s[22:0];
    exp_fin_s  = s2_exp_r + {9'd0, norm_s} + {9'd0, mant_rnd_s[24]};

    res_data_s  = 32'h0000_0000;
    res_flags_s = 3'b000;
    if (s2_inv_r) begin
      res_data_s            = QNAN;
      res_flags_s[FLAG_INV] = 1'b1;
    end else if (s2_inf_r) begin
      res_data_s = {s2_sign_r, EXP_ALL, 23'h0};
    end else if (s2_zero_r) begin
      res_data_s = {s2_sign_r, 31'h0};
    end else if ($signed(exp_fin_s) >= 10'sd255) begin
      res_data_s            = {s2_sign_r, EXP_ALL, 23'h0};
      res_flags_s[FLAG_OVF] = 1'b1;
    end else if ($signed(exp_fin_s) <= 10'sd0) begin
      res_data_s            = {s2_sign_r, 31'h0};
      res_flags_s[FLAG_UNF] = 1'b1;
    end else begin
      res_data_s = {s2_sign_r, exp_fin_s[7:0], frac_s};
    end
  end

  // S3 output register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= 32'h0000_0000;
      out_flags <= 3'b000;
    end else begin
      out_valid <= s2_valid_r;
      out_idx   <= s2_idx_r;
      out_data  <= res_data_s;
      out_flags <= res_flags_s;
    end
  end

endmodule

// File: rtl/vec_fp_mul_engine.sv
// -----------------------------------------------------------------------------
// vec_fp_mul_engine
// Vector binary32 multiplier: C[i] = A[i] * B[i] for i = 0..VLEN-1.
// Owns operand banks A/B, result bank C (data + flags), the run FSM, the
// issue pointer and the sticky flag accumulator.
// Ports:
//   Clk, reset                     clock / async active-low reset
//   ld_en, ld_sel, ld_addr, ld_data operand load (ignored while busy)
//   start                          begin a run (sampled in IDLE only)
//   busy, done                     run status / one-cycle completion pulse
//   rd_addr, rd_data, rd_flags     result readback, 1-cycle latency
//   sticky_flags                   OR of {inv, ovf, unf} since last start
// -----------------------------------------------------------------------------
module vec_fp_mul_engine
  import vfpm_pkg::*;
#(
  parameter int VLEN = 32,
  parameter int AW   = $clog2(VLEN)
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic [2:0]    rd_flags,
  output logic [2:0]    sticky_flags
);

  localparam logic [AW-1:0] LAST_IDX = AW'(VLEN - 1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  state_e        state_r;
  state_e        state_n;
  logic [AW-1:0] ptr_r;
  logic [1:0]    drain_cnt_r;
  logic          busy_r;
  logic          done_r;
  logic [31:0]   rd_data_r;
  logic [2:0]    rd_flags_r;
  logic [2:0]    sticky_r;
  logic          issue_valid_s;
  logic          start_acc_s;

  logic [31:0] a_bank_r   [VLEN];
  logic [31:0] b_bank_r   [VLEN];
  logic [31:0] res_data_r [VLEN];
  logic [2:0]  res_flags_r[VLEN];

  logic          p_valid_s;
  logic [AW-1:0] p_idx_s;
  logic [31:0]   p_data_s;
  logic [2:0]    p_flags_s;

  assign busy         = busy_r;
  assign done         = done_r;
  assign rd_data      = rd_data_r;
  assign rd_flags     = rd_flags_r;
  assign sticky_flags = sticky_r;

  // FSM state register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state and issue control
  always_comb begin
    state_n       = state_r;
    issue_valid_s = 1'b0;
    start_acc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n     = ST_RUN;
          start_acc_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue_valid_s = 1'b1;
        if (ptr_r == LAST_IDX) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // done_r is high exactly in the cycle the last result is written.
        if (done_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Issue pointer, drain timer and registered status outputs
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      ptr_r       <= '0;
      drain_cnt_r <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (start_acc_s) begin
        ptr_r <= '0;
      end else if (issue_valid_s) begin
        ptr_r <= ptr_r + ONE_IDX;
      end
      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_cnt_r + 2'd1;
      end else begin
        drain_cnt_r <= 2'd0;
      end
      // Last element sits in S2 during the second DRAIN cycle, so the pulse
      // lands on the cycle its S3 result is written to the bank.
      done_r <= (state_r == ST_DRAIN) && (drain_cnt_r == 2'd1);
      busy_r <= (state_n != ST_IDLE);
    end
  end

  // Operand bank writes, only accepted while idle
  always_ff @(posedge Clk) begin
    if (ld_en && (state_r == ST_IDLE)) begin
      if (ld_sel) begin
        b_bank_r[ld_addr] <= ld_data;
      end else begin
        a_bank_r[ld_addr] <= ld_data;
      end
    end
  end

  // Result bank writes from the pipeline output
  always_ff @(posedge Clk) begin
    if (p_valid_s) begin
      res_data_r[p_idx_s]  <= p_data_s;
      res_flags_r[p_idx_s] <= p_flags_s;
    end
  end

  // Readback registers (read-before-write against the bank) and sticky flags
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rd_data_r  <= 32'h0000_0000;
      rd_flags_r <= 3'b000;
      sticky_r   <= 3'b000;
    end else begin
      rd_data_r  <= res_data_r[rd_addr];
      rd_flags_r <= res_flags_r[rd_addr];
      if (start_acc_s) begin
        sticky_r <= 3'b000;
      end else if (p_valid_s) begin
        sticky_r <= sticky_r | p_flags_s;
      end
    end
  end

  fp32_mul_pipe #(
    .AW (AW)
  ) u_pipe (
    .Clk       (Clk),
    .reset     (reset),
    .in_valid  (issue_valid_s),
    .in_idx    (ptr_r),
    .in_a      (a_bank_r[ptr_r]),
    .in_b      (b_bank_r[ptr_r]),
    .out_valid (p_valid_s),
    .out_idx   (p_idx_s),
    .out_data  (p_data_s),
    .out_flags (p_flags_s)
  );

endmodule
